// File: rtl/bc_msg_arbiter.sv
// ---------------------------------------------------------------------------
// bc_msg_arbiter
//   Serialises broadcast messages from CORE_COUNT cores onto one broadcast
//   bus. Each core has a small FIFO. A round-robin arbiter pops at most one
//   FIFO per cycle into a read register. A PIPE_STAGES-deep register pipe then
//   carries that message across the die. The bus has no backpressure.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   core_msg_in         core i message at [i*MSG_WIDTH +: MSG_WIDTH]
//   core_msg_in_valid   per-core message valid
//   core_msg_in_ready   per-core ready (FIFO not full, low while rst)
//   bc_msg_out          broadcast message (zero while the bus is idle)
//   bc_msg_out_valid    one-cycle pulse per message
//   bc_msg_out_src      index of the originating core
//   fifo_full           registered per-core FIFO-full status
// ---------------------------------------------------------------------------
module bc_msg_arbiter #(
  parameter int CORE_COUNT    = 16,
  parameter int MSG_WIDTH     = 46,
  parameter int FIFO_DEPTH    = 4,
  parameter int PIPE_STAGES   = 2,
  parameter int CORE_ID_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg_in,
  input  logic [CORE_COUNT-1:0]           core_msg_in_valid,
  output logic [CORE_COUNT-1:0]           core_msg_in_ready,
  output logic [MSG_WIDTH-1:0]            bc_msg_out,
  output logic                            bc_msg_out_valid,
  output logic [CORE_ID_WIDTH-1:0]        bc_msg_out_src,
  output logic [CORE_COUNT-1:0]           fifo_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                     vld;
    logic [CORE_ID_WIDTH-1:0] src;
    logic [MSG_WIDTH-1:0]     msg;
  } beat_t;

  logic [MSG_WIDTH-1:0]     mem    [CORE_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr [CORE_COUNT];
  logic [PTR_W-1:0]         rd_ptr [CORE_COUNT];
  logic [CNT_W-1:0]         count  [CORE_COUNT];

  logic [CORE_COUNT-1:0]    push;
  logic [CORE_COUNT-1:0]    pop;
  logic [CORE_ID_WIDTH-1:0] last_grant;

  logic                     hi_vld, lo_vld, grant_vld;
  logic [CORE_ID_WIDTH-1:0] hi_idx, lo_idx, grant_idx;
  logic [MSG_WIDTH-1:0]     head_msg;
  beat_t                    grant_beat;
  beat_t                    rd_q;
  beat_t                    pipe_q [PIPE_STAGES];

  // Ready comes only from the registered full flag, so there is no
  // combinational path from valid to ready.
  assign core_msg_in_ready = rst ? '0 : ~fifo_full;
  assign push              = core_msg_in_valid & core_msg_in_ready;

  // Round robin: the lowest non-empty core above last_grant wins. If there is
  // none, the lowest non-empty core at or below last_grant wins (the wrap).
  // NOTE: every variable assigned here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int c = CORE_COUNT - 1; c >= 0; c--) begin
      if (count[c] != '0) begin
        if (c > int'(last_grant)) begin
          hi_vld = 1'b1;
          hi_idx = CORE_ID_WIDTH'(c);
        end else begin
          lo_vld = 1'b1;
          lo_idx = CORE_ID_WIDTH'(c);
        end
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  assign pop      = grant_vld ? (CORE_COUNT'(1) << grant_idx) : '0;
  assign head_msg = mem[grant_idx][rd_ptr[grant_idx]];

  // An idle slot carries zeros so the bus never shows stale or X data.
  assign grant_beat = grant_vld ? '{vld: 1'b1, src: grant_idx, msg: head_msg} : '0;

  // FIFO bookkeeping. Occupancy is one bit wider than the pointers so that
  // full and empty are distinct.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      fifo_full <= '0;
    end else begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        unique case ({push[c], pop[c]})
          2'b10: begin
            count[c]     <= count[c] + 1'b1;
            fifo_full[c] <= (count[c] == CNT_W'(FIFO_DEPTH - 1));
          end
          2'b01: begin
            count[c]     <= count[c] - 1'b1;
            fifo_full[c] <= 1'b0;
          end
          default: ; // idle, or push and pop together: occupancy unchanged
        endcase
      end
    end
  end

  // NOTE: the message storage has no reset. Occupancy alone decides which
  // entries are live, and leaving the array unreset lets it map onto plain
  // RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= core_msg_in[c*MSG_WIDTH +: MSG_WIDTH];
    end
  end

  // The read register (FIFO read stage) is followed by the PIPE_STAGES
  // pipeline registers. The pipe shifts every cycle and never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) pipe_q[s] <= '0;
      last_grant <= CORE_ID_WIDTH'(CORE_COUNT - 1);
    end else begin
      rd_q      <= grant_beat;
      pipe_q[0] <= rd_q;
      for (int s = 1; s < PIPE_STAGES; s++) pipe_q[s] <= pipe_q[s-1];
      if (grant_vld) last_grant <= grant_idx;
    end
  end

  assign bc_msg_out       = pipe_q[PIPE_STAGES-1].msg;
  assign bc_msg_out_valid = pipe_q[PIPE_STAGES-1].vld;
  assign bc_msg_out_src   = pipe_q[PIPE_STAGES-1].src;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bc_msg_arbiter
//   Self-checking bench for bc_msg_arbiter. A behavioural model keeps one
//   queue per core and a delay line of expected bus beats. Inputs are driven
//   just after the rising edge. Outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_bc_msg_arbiter;

  localparam int CC  = 16;
  localparam int MSW = 46;
  localparam int FD  = 4;
  localparam int PS  = 2;
  localparam int IDW = 4;
  localparam int DLY = PS + 1;   // pop-to-bus latency in edges

  logic              clk = 1'b0;
  logic              rst;
  logic [CC*MSW-1:0] core_msg_in;
  logic [CC-1:0]     core_msg_in_valid;
  logic [CC-1:0]     core_msg_in_ready;
  logic [MSW-1:0]    bc_msg_out;
  logic              bc_msg_out_valid;
  logic [IDW-1:0]    bc_msg_out_src;
  logic [CC-1:0]     fifo_full;

  bc_msg_arbiter #(
    .CORE_COUNT(CC), .MSG_WIDTH(MSW), .FIFO_DEPTH(FD),
    .PIPE_STAGES(PS), .CORE_ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .core_msg_in(core_msg_in), .core_msg_in_valid(core_msg_in_valid),
    .core_msg_in_ready(core_msg_in_ready),
    .bc_msg_out(bc_msg_out), .bc_msg_out_valid(bc_msg_out_valid),
    .bc_msg_out_src(bc_msg_out_src), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Reference model state.
  logic [MSW-1:0] mq     [CC][$];
  logic           m_vld  [DLY];
  logic [MSW-1:0] m_msg  [DLY];
  int             m_src  [DLY];
  int             m_last;
  logic [CC-1:0]  last_acc;

  // Log of observed bus beats.
  int             obs_src [$];
  int             obs_cyc [$];
  logic [MSW-1:0] obs_msg [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CC; c++) mq[c].delete();
    for (int s = 0; s < DLY; s++) begin
      m_vld[s] = 1'b0;
      m_msg[s] = '0;
      m_src[s] = 0;
    end
    m_last = CC - 1;
  endtask

  // One clock edge of the model, using the inputs as they stand before the edge.
  task automatic model_edge();
    logic [CC-1:0] acc;
    int g;
    for (int c = 0; c < CC; c++)
      acc[c] = !rst && core_msg_in_valid[c] && (mq[c].size() < FD);
    last_acc = acc;
    if (rst) begin
      model_reset();
      return;
    end
    for (int s = DLY - 1; s > 0; s--) begin
      m_vld[s] = m_vld[s-1];
      m_msg[s] = m_msg[s-1];
      m_src[s] = m_src[s-1];
    end
    g = -1;
    for (int k = 1; k <= CC; k++)
      if (g < 0 && mq[(m_last + k) % CC].size() != 0) g = (m_last + k) % CC;
    m_vld[0] = (g >= 0);
    if (g >= 0) begin
      m_msg[0] = mq[g].pop_front();
      m_src[0] = g;
      m_last   = g;
    end
    for (int c = 0; c < CC; c++)
      if (acc[c]) mq[c].push_back(core_msg_in[c*MSW +: MSW]);
  endtask

  task automatic compare();
    logic [CC-1:0] er, ef;
    for (int c = 0; c < CC; c++) begin
      ef[c] = (mq[c].size() == FD);
      er[c] = !rst && !ef[c];
    end
    check("ready", 64'(core_msg_in_ready), 64'(er));
    check("fifo_full", 64'(fifo_full), 64'(ef));
    check("out_valid", 64'(bc_msg_out_valid), 64'(m_vld[DLY-1]));
    if (m_vld[DLY-1]) begin
      check("out_msg", 64'(bc_msg_out), 64'(m_msg[DLY-1]));
      check("out_src", 64'(bc_msg_out_src), 64'(m_src[DLY-1]));
    end
    if (bc_msg_out_valid === 1'b1) begin
      obs_src.push_back(int'(bc_msg_out_src));
      obs_cyc.push_back(cycle);
      obs_msg.push_back(bc_msg_out);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_edge();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic clear_obs();
    obs_src.delete();
    obs_cyc.delete();
    obs_msg.delete();
  endtask

  task automatic idle(input int n);
    core_msg_in_valid = '0;
    repeat (n) step();
  endtask

  function automatic logic [MSW-1:0] rand_msg();
    return MSW'({$urandom, $urandom});
  endfunction

  // One message from one core into an idle system. It must appear on the bus
  // exactly once, DLY edges after the accepting edge.
  task automatic single_msg(input int core, input logic [MSW-1:0] m, input string tag);
    int acc_edge;
    clear_obs();
    core_msg_in_valid       = '0;
    core_msg_in_valid[core] = 1'b1;
    core_msg_in[core*MSW +: MSW] = m;
    step();
    acc_edge = cycle;
    idle(10);
    check({tag, "_count"}, 64'(obs_src.size()), 64'd1);
    if (obs_src.size() >= 1) begin
      check({tag, "_latency"}, 64'(obs_cyc[0] - acc_edge), 64'(PS + 1));
      check({tag, "_msg"}, 64'(obs_msg[0]), 64'(m));
      check({tag, "_src"}, 64'(obs_src[0]), 64'(core));
    end
  endtask

  initial begin
    int seq [CC];
    int breaks, in_phase, end_cyc, load;
    logic [31:0] dword;

    rst = 1'b1;
    core_msg_in = '0;
    core_msg_in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    // Reset state: outputs are zero and ready is held low while rst is high.
    check("rst_msg", 64'(bc_msg_out), 64'd0);
    check("rst_src", 64'(bc_msg_out_src), 64'd0);
    step();
    rst = 1'b0;

    // Single message from core 3.
    single_msg(3, {32'h1234_5678, 4'hF, 10'h010}, "single3");

    // Wrap: core 15 is granted, then cores 15 and 2 are both pending.
    clear_obs();
    core_msg_in_valid = '0;
    core_msg_in_valid[15] = 1'b1;
    core_msg_in[15*MSW +: MSW] = rand_msg();
    step();
    core_msg_in_valid[2] = 1'b1;
    core_msg_in[15*MSW +: MSW] = rand_msg();
    core_msg_in[2*MSW +: MSW]  = rand_msg();
    step();
    idle(10);
    check("wrap_count", 64'(obs_src.size()), 64'd3);
    if (obs_src.size() == 3) begin
      check("wrap_src0", 64'(obs_src[0]), 64'd15);
      check("wrap_src1", 64'(obs_src[1]), 64'd2);
      check("wrap_src2", 64'(obs_src[2]), 64'd15);
    end

    // One core pushes every cycle. The FIFO holds a single entry, so ready
    // must stay high (checked by compare) and the order must be kept.
    for (int i = 0; i < 10; i++) begin
      core_msg_in_valid = '0;
      core_msg_in_valid[7] = 1'b1;
      core_msg_in[7*MSW +: MSW] = rand_msg();
      step();
    end
    idle(8);

    // All cores backlogged straight after a reset: strict rotation from core
    // 0, one message per cycle, incrementing data per core.
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_obs();
    for (int c = 0; c < CC; c++) seq[c] = 0;
    for (int i = 0; i < 200; i++) begin
      for (int c = 0; c < CC; c++) begin
        dword = 32'(c << 24) | 32'(seq[c]);
        core_msg_in[c*MSW +: MSW] = {dword, 4'hF, 10'(c)};
      end
      core_msg_in_valid = '1;
      step();
      for (int c = 0; c < CC; c++) if (last_acc[c]) seq[c]++;
    end
    end_cyc = cycle;
    breaks = 0;
    in_phase = 0;
    for (int i = 0; i < obs_src.size(); i++) begin
      if (obs_cyc[i] <= end_cyc) begin
        in_phase++;
        if (i > 0 && (obs_cyc[i] != obs_cyc[i-1] + 1 || obs_src[i] != (obs_src[i-1] + 1) % CC))
          breaks++;
      end
    end
    check("rr_first_src", 64'(obs_src.size() > 0 ? obs_src[0] : -1), 64'd0);
    check("rr_breaks", 64'(breaks), 64'd0);
    check("rr_rate_ok", 64'(in_phase >= 200 - DLY - 2), 64'd1);

    // Mid-stream reset with a full pipe and full FIFOs: nothing may come out
    // afterwards, and a new message from core 0 has the normal latency.
    core_msg_in_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_obs();
    idle(8);
    check("post_rst_quiet", 64'(obs_src.size()), 64'd0);
    single_msg(0, rand_msg(), "post_rst0");

    // Random traffic at several loads, with occasional one-cycle resets.
    for (int p = 0; p < 3; p++) begin
      load = (p == 0) ? 25 : (p == 1) ? 60 : 90;
      for (int i = 0; i < 300; i++) begin
        for (int c = 0; c < CC; c++) begin
          core_msg_in_valid[c] = ($urandom_range(99) < load);
          core_msg_in[c*MSW +: MSW] = rand_msg();
        end
        rst = ($urandom_range(149) == 0);
        step();
      end
      rst = 1'b0;
    end
    idle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
